// File: rtl/cluster_axi_err_slv.sv
// rtl/cluster_axi_err_slv.sv - AXI4 error slave that ends every transaction with DECERR
//
// Purpose:
//   This module terminates any AXI4 transaction that reaches an unmapped crossbar
//   master port. Writes are answered with one B beat and reads with arlen+1 R beats.
//   Every response is DECERR, and nothing is forwarded.
//   The write and read channels run independent FSMs. Each FSM allows one
//   outstanding transaction.
//
// Optional feature:
//   CLUSTER_AXI_ERR_SLV_CNT_EN adds err_cnt_o, a saturating 16-bit count of
//   terminated transactions. One count is added per B handshake and one per last
//   R handshake.
//
// Ports:
//   clk_i        single clock
//   rst_ni       asynchronous active-low reset
//   err_cnt_o    terminated-transaction count (only with CLUSTER_AXI_ERR_SLV_CNT_EN)
//   slv_aw_*     AW channel of the AXI_BUS slave port (payload ignored except id)
//   slv_w_*      W channel (data/strobe discarded, only wlast is used)
//   slv_b_*      B channel (bid = latched awid, bresp = DECERR, buser = 0)
//   slv_ar_*     AR channel (id and len used)
//   slv_r_*      R channel (rdata = RESP_DATA, rresp = DECERR, ruser = 0)

module cluster_axi_err_slv #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter logic [63:0] RESP_DATA      = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
`ifdef CLUSTER_AXI_ERR_SLV_CNT_EN
  output logic [15:0]                 err_cnt_o,
`endif
  // AW
  input  logic [AXI_ID_WIDTH-1:0]     slv_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   slv_aw_addr,
  input  logic [7:0]                  slv_aw_len,
  input  logic [2:0]                  slv_aw_size,
  input  logic [1:0]                  slv_aw_burst,
  input  logic                        slv_aw_lock,
  input  logic [3:0]                  slv_aw_cache,
  input  logic [2:0]                  slv_aw_prot,
  input  logic [3:0]                  slv_aw_qos,
  input  logic [3:0]                  slv_aw_region,
  input  logic [AXI_USER_WIDTH-1:0]   slv_aw_user,
  input  logic                        slv_aw_valid,
  output logic                        slv_aw_ready,
  // W
  input  logic [AXI_DATA_WIDTH-1:0]   slv_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] slv_w_strb,
  input  logic                        slv_w_last,
  input  logic [AXI_USER_WIDTH-1:0]   slv_w_user,
  input  logic                        slv_w_valid,
  output logic                        slv_w_ready,
  // B
  output logic [AXI_ID_WIDTH-1:0]     slv_b_id,
  output logic [1:0]                  slv_b_resp,
  output logic [AXI_USER_WIDTH-1:0]   slv_b_user,
  output logic                        slv_b_valid,
  input  logic                        slv_b_ready,
  // AR
  input  logic [AXI_ID_WIDTH-1:0]     slv_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0]   slv_ar_addr,
  input  logic [7:0]                  slv_ar_len,
  input  logic [2:0]                  slv_ar_size,
  input  logic [1:0]                  slv_ar_burst,
  input  logic                        slv_ar_lock,
  input  logic [3:0]                  slv_ar_cache,
  input  logic [2:0]                  slv_ar_prot,
  input  logic [3:0]                  slv_ar_qos,
  input  logic [3:0]                  slv_ar_region,
  input  logic [AXI_USER_WIDTH-1:0]   slv_ar_user,
  input  logic                        slv_ar_valid,
  output logic                        slv_ar_ready,
  // R
  output logic [AXI_ID_WIDTH-1:0]     slv_r_id,
  output logic [AXI_DATA_WIDTH-1:0]   slv_r_data,
  output logic [1:0]                  slv_r_resp,
  output logic                        slv_r_last,
  output logic [AXI_USER_WIDTH-1:0]   slv_r_user,
  output logic                        slv_r_valid,
  input  logic                        slv_r_ready
);

  localparam logic [1:0] RESP_DECERR = 2'b11;
  // Narrower buses keep the low bits of the pattern; wider buses zero-extend it.
  localparam logic [AXI_DATA_WIDTH-1:0] R_PATTERN = AXI_DATA_WIDTH'(RESP_DATA);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  w_state_e                 w_state_q, w_state_d;
  r_state_e                 r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]  aw_id_q;
  logic [AXI_ID_WIDTH-1:0]  ar_id_q;
  logic [7:0]               beat_cnt_q, beat_cnt_d;

  logic aw_hs;
  logic b_hs;
  logic ar_hs;
  logic r_last_hs;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_id_q <= slv_aw_id;
      end
    end
  end

  always_comb begin
    w_state_d    = w_state_q;
    slv_aw_ready = 1'b0;
    slv_w_ready  = 1'b0;
    slv_b_valid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        slv_aw_ready = 1'b1;
        if (slv_aw_valid) begin
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // The burst ends at wlast. awlen is deliberately not cross-checked.
        slv_w_ready = 1'b1;
        if (slv_w_valid && slv_w_last) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        slv_b_valid = 1'b1;
        if (slv_b_ready) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  assign aw_hs      = slv_aw_valid & slv_aw_ready;
  assign b_hs       = slv_b_valid & slv_b_ready;
  assign slv_b_id   = aw_id_q;
  assign slv_b_resp = RESP_DECERR;
  assign slv_b_user = '0;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      beat_cnt_q <= 8'd0;
    end else begin
      r_state_q  <= r_state_d;
      beat_cnt_q <= beat_cnt_d;
      if (ar_hs) begin
        ar_id_q <= slv_ar_id;
      end
    end
  end

  always_comb begin
    r_state_d    = r_state_q;
    beat_cnt_d   = beat_cnt_q;
    slv_ar_ready = 1'b0;
    slv_r_valid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        slv_ar_ready = 1'b1;
        if (slv_ar_valid) begin
          r_state_d  = R_DATA;
          beat_cnt_d = slv_ar_len;
        end
      end
      R_DATA: begin
        // The counter holds the number of beats left after the current one.
        // It only counts down, so arlen=255 gives 256 beats without wrapping.
        slv_r_valid = 1'b1;
        if (slv_r_ready) begin
          if (beat_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  assign ar_hs      = slv_ar_valid & slv_ar_ready;
  assign slv_r_last = (r_state_q == R_DATA) && (beat_cnt_q == 8'd0);
  assign r_last_hs  = slv_r_valid & slv_r_ready & slv_r_last;
  assign slv_r_id   = ar_id_q;
  assign slv_r_data = R_PATTERN;
  assign slv_r_resp = RESP_DECERR;
  assign slv_r_user = '0;

  // ---------------------------------------------------------------------------
  // Optional terminated-transaction counter
  // ---------------------------------------------------------------------------
`ifdef CLUSTER_AXI_ERR_SLV_CNT_EN
  logic [15:0] err_cnt_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // A B completion and a read completion can land in the same cycle, so the step is 0..2.
  assign err_inc = {1'b0, b_hs} + {1'b0, r_last_hs};
  assign err_sum = {1'b0, err_cnt_q} + {15'd0, err_inc};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 16'd0;
    end else if (err_sum[16]) begin
      err_cnt_q <= 16'hFFFF;
    end else begin
      err_cnt_q <= err_sum[15:0];
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_events;
  assign unused_events = b_hs ^ r_last_hs;
`endif

  // Request payload that has no effect on the DECERR response.
  logic unused_inputs;
  assign unused_inputs = ^{slv_aw_addr, slv_aw_len, slv_aw_size, slv_aw_burst,
                           slv_aw_lock, slv_aw_cache, slv_aw_prot, slv_aw_qos,
                           slv_aw_region, slv_aw_user, slv_w_data, slv_w_strb,
                           slv_w_user, slv_ar_addr, slv_ar_size, slv_ar_burst,
                           slv_ar_lock, slv_ar_cache, slv_ar_prot, slv_ar_qos,
                           slv_ar_region, slv_ar_user};

endmodule

// File: tb/tb_cluster_axi_err_slv.sv
// tb/tb_cluster_axi_err_slv.sv - self-checking bench for cluster_axi_err_slv
module tb_cluster_axi_err_slv;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 6;
  localparam int UW = 6;
  localparam logic [63:0] RESP = 64'hBADC_AB1E_BADC_AB1E;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst_n;

  logic [IW-1:0]   slv_aw_id;
  logic [AW-1:0]   slv_aw_addr;
  logic [7:0]      slv_aw_len;
  logic [2:0]      slv_aw_size;
  logic [1:0]      slv_aw_burst;
  logic            slv_aw_lock;
  logic [3:0]      slv_aw_cache;
  logic [2:0]      slv_aw_prot;
  logic [3:0]      slv_aw_qos;
  logic [3:0]      slv_aw_region;
  logic [UW-1:0]   slv_aw_user;
  logic            slv_aw_valid;
  logic            slv_aw_ready;
  logic [DW-1:0]   slv_w_data;
  logic [DW/8-1:0] slv_w_strb;
  logic            slv_w_last;
  logic [UW-1:0]   slv_w_user;
  logic            slv_w_valid;
  logic            slv_w_ready;
  logic [IW-1:0]   slv_b_id;
  logic [1:0]      slv_b_resp;
  logic [UW-1:0]   slv_b_user;
  logic            slv_b_valid;
  logic            slv_b_ready;
  logic [IW-1:0]   slv_ar_id;
  logic [AW-1:0]   slv_ar_addr;
  logic [7:0]      slv_ar_len;
  logic [2:0]      slv_ar_size;
  logic [1:0]      slv_ar_burst;
  logic            slv_ar_lock;
  logic [3:0]      slv_ar_cache;
  logic [2:0]      slv_ar_prot;
  logic [3:0]      slv_ar_qos;
  logic [3:0]      slv_ar_region;
  logic [UW-1:0]   slv_ar_user;
  logic            slv_ar_valid;
  logic            slv_ar_ready;
  logic [IW-1:0]   slv_r_id;
  logic [DW-1:0]   slv_r_data;
  logic [1:0]      slv_r_resp;
  logic            slv_r_last;
  logic [UW-1:0]   slv_r_user;
  logic            slv_r_valid;
  logic            slv_r_ready;
`ifdef CLUSTER_AXI_ERR_SLV_CNT_EN
  logic [15:0]     err_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  cluster_axi_err_slv #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH  (IW),
    .AXI_USER_WIDTH(UW),
    .RESP_DATA     (RESP)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
`ifdef CLUSTER_AXI_ERR_SLV_CNT_EN
    .err_cnt_o    (err_cnt_o),
`endif
    .slv_aw_id    (slv_aw_id),
    .slv_aw_addr  (slv_aw_addr),
    .slv_aw_len   (slv_aw_len),
    .slv_aw_size  (slv_aw_size),
    .slv_aw_burst (slv_aw_burst),
    .slv_aw_lock  (slv_aw_lock),
    .slv_aw_cache (slv_aw_cache),
    .slv_aw_prot  (slv_aw_prot),
    .slv_aw_qos   (slv_aw_qos),
    .slv_aw_region(slv_aw_region),
    .slv_aw_user  (slv_aw_user),
    .slv_aw_valid (slv_aw_valid),
    .slv_aw_ready (slv_aw_ready),
    .slv_w_data   (slv_w_data),
    .slv_w_strb   (slv_w_strb),
    .slv_w_last   (slv_w_last),
    .slv_w_user   (slv_w_user),
    .slv_w_valid  (slv_w_valid),
    .slv_w_ready  (slv_w_ready),
    .slv_b_id     (slv_b_id),
    .slv_b_resp   (slv_b_resp),
    .slv_b_user   (slv_b_user),
    .slv_b_valid  (slv_b_valid),
    .slv_b_ready  (slv_b_ready),
    .slv_ar_id    (slv_ar_id),
    .slv_ar_addr  (slv_ar_addr),
    .slv_ar_len   (slv_ar_len),
    .slv_ar_size  (slv_ar_size),
    .slv_ar_burst (slv_ar_burst),
    .slv_ar_lock  (slv_ar_lock),
    .slv_ar_cache (slv_ar_cache),
    .slv_ar_prot  (slv_ar_prot),
    .slv_ar_qos   (slv_ar_qos),
    .slv_ar_region(slv_ar_region),
    .slv_ar_user  (slv_ar_user),
    .slv_ar_valid (slv_ar_valid),
    .slv_ar_ready (slv_ar_ready),
    .slv_r_id     (slv_r_id),
    .slv_r_data   (slv_r_data),
    .slv_r_resp   (slv_r_resp),
    .slv_r_last   (slv_r_last),
    .slv_r_user   (slv_r_user),
    .slv_r_valid  (slv_r_valid),
    .slv_r_ready  (slv_r_ready)
  );

  // Table record: for writes len = number of W beats, for reads len = arlen.
  typedef struct {
    bit          is_read;
    logic [5:0]  id;
    int          len;
    int          bdelay;
    bit          rnd_ready;
    logic [5:0]  exp_id;
    int          exp_beats;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each terminated transaction adds one, saturating at 16 bits.
  function automatic void model_done(input int k);
    exp_cnt = (exp_cnt + k > 65535) ? 65535 : exp_cnt + k;
  endfunction

  task automatic check_cnt(input string name);
`ifdef CLUSTER_AXI_ERR_SLV_CNT_EN
    check(name, 64'(err_cnt_o), 64'(exp_cnt));
`endif
  endtask

  task automatic do_write(input logic [IW-1:0] id, input int nbeats, input int bdelay,
                          input logic [IW-1:0] exp_id, input logic [1:0] exp_resp);
    int n;
    check("w_ready_before_aw", 64'(slv_w_ready), 64'(0));
    check("aw_ready_idle", 64'(slv_aw_ready), 64'(1));
    slv_aw_id    = id;
    slv_aw_len   = 8'($urandom);   // awlen intentionally unrelated to the real beat count
    slv_aw_addr  = $urandom;
    slv_aw_valid = 1'b1;
    step();
    slv_aw_valid = 1'b0;
    check("w_ready_lat", 64'(slv_w_ready), 64'(1));
    check("aw_ready_busy", 64'(slv_aw_ready), 64'(0));
    for (int b = 0; b < nbeats; b++) begin
      slv_w_valid = 1'b0;
      repeat ($urandom_range(0, 1)) step();
      slv_w_valid = 1'b1;
      slv_w_last  = (b == nbeats - 1);
      slv_w_data  = {$urandom, $urandom};
      slv_w_strb  = 8'($urandom);
      n = 0;
      while (!slv_w_ready && n < BUDGET) begin
        step();
        n++;
      end
      if (n >= BUDGET) begin
        check("w_ready_wait", 64'(slv_w_ready), 64'(1));
        slv_w_valid = 1'b0;
        slv_w_last  = 1'b0;
        return;
      end
      check("b_valid_early", 64'(slv_b_valid), 64'(0));
      step();
    end
    slv_w_valid = 1'b0;
    slv_w_last  = 1'b0;
    check("b_valid_lat", 64'(slv_b_valid), 64'(1));
    check("b_id", 64'(slv_b_id), 64'(exp_id));
    check("b_resp", 64'(slv_b_resp), 64'(exp_resp));
    check("w_ready_resp", 64'(slv_w_ready), 64'(0));
    for (int d = 0; d < bdelay; d++) begin
      step();
      check("b_valid_hold", 64'(slv_b_valid), 64'(1));
      check("b_id_hold", 64'(slv_b_id), 64'(exp_id));
    end
    slv_b_ready = 1'b1;
    step();
    slv_b_ready = 1'b0;
    model_done(1);
    check("b_valid_done", 64'(slv_b_valid), 64'(0));
    check("aw_ready_after_b", 64'(slv_aw_ready), 64'(1));
  endtask

  task automatic do_read(input logic [IW-1:0] id, input int len, input bit rnd_ready,
                         input logic [IW-1:0] exp_id, input int exp_beats,
                         input logic [1:0] exp_resp);
    int beat;
    int n;
    check("ar_ready_idle", 64'(slv_ar_ready), 64'(1));
    slv_ar_id    = id;
    slv_ar_len   = 8'(len);
    slv_ar_addr  = $urandom;
    slv_ar_valid = 1'b1;
    step();
    slv_ar_valid = 1'b0;
    beat = 0;
    n    = 0;
    while (beat < exp_beats && n < exp_beats * 8 + BUDGET) begin
      check("r_valid", 64'(slv_r_valid), 64'(1));
      check("r_id", 64'(slv_r_id), 64'(exp_id));
      check("r_data", 64'(slv_r_data), RESP);
      check("r_resp", 64'(slv_r_resp), 64'(exp_resp));
      check("r_last", 64'(slv_r_last), 64'(beat == exp_beats - 1));
      check("ar_ready_busy", 64'(slv_ar_ready), 64'(0));
      slv_r_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (slv_r_ready) beat++;
      n++;
    end
    slv_r_ready = 1'b0;
    check("r_beat_count", 64'(beat), 64'(exp_beats));
    model_done(1);
    check("r_valid_done", 64'(slv_r_valid), 64'(0));
    check("ar_ready_after_r", 64'(slv_ar_ready), 64'(1));
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_read) do_read(v.id, v.len, v.rnd_ready, v.exp_id, v.exp_beats, v.exp_resp);
    else           do_write(v.id, v.len, v.bdelay, v.exp_id, v.exp_resp);
    check_cnt("cnt_after_vec");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [IW-1:0] rid;
    logic [IW-1:0] wid;
    int rlen;
    int wbeats;

    vecs[0] = '{0, 6'h15,   4, 2, 0, 6'h15,   1, 2'b11};
    vecs[1] = '{1, 6'h2A,   3, 0, 0, 6'h2A,   4, 2'b11};
    vecs[2] = '{1, 6'h01,   0, 0, 1, 6'h01,   1, 2'b11};
    vecs[3] = '{0, 6'h3F,   1, 0, 0, 6'h3F,   1, 2'b11};
    vecs[4] = '{1, 6'h00, 255, 0, 1, 6'h00, 256, 2'b11};
    vecs[5] = '{0, 6'h00,  16, 5, 0, 6'h00,   1, 2'b11};
    vecs[6] = '{1, 6'h3F,   1, 0, 1, 6'h3F,   2, 2'b11};

    rst_n = 1'b0;
    {slv_aw_id, slv_aw_addr, slv_aw_len, slv_aw_size, slv_aw_burst, slv_aw_lock} = '0;
    {slv_aw_cache, slv_aw_prot, slv_aw_qos, slv_aw_region, slv_aw_user, slv_aw_valid} = '0;
    {slv_w_data, slv_w_strb, slv_w_last, slv_w_user, slv_w_valid, slv_b_ready} = '0;
    {slv_ar_id, slv_ar_addr, slv_ar_len, slv_ar_size, slv_ar_burst, slv_ar_lock} = '0;
    {slv_ar_cache, slv_ar_prot, slv_ar_qos, slv_ar_region, slv_ar_user, slv_ar_valid} = '0;
    slv_r_ready = 1'b0;

    #12;
    check("rst_aw_ready", 64'(slv_aw_ready), 64'(1));
    check("rst_ar_ready", 64'(slv_ar_ready), 64'(1));
    check("rst_w_ready", 64'(slv_w_ready), 64'(0));
    check("rst_b_valid", 64'(slv_b_valid), 64'(0));
    check("rst_r_valid", 64'(slv_r_valid), 64'(0));
    check_cnt("rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven directed transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // AW and AR in the same cycle, arlen=0, always ready
    c0 = exp_cnt;
    fork
      do_write(6'h05, 1, 0, 6'h05, 2'b11);
      do_read(6'h06, 0, 0, 6'h06, 1, 2'b11);
    join
    check_cnt("cnt_parallel_plus2");

    // B handshake and last R handshake land in the same cycle
    c0 = exp_cnt;
    slv_aw_id = 6'h0A; slv_aw_valid = 1'b1;
    slv_ar_id = 6'h0B; slv_ar_len = 8'd1; slv_ar_valid = 1'b1;
    slv_r_ready = 1'b1; slv_b_ready = 1'b1;
    step();
    slv_aw_valid = 1'b0; slv_ar_valid = 1'b0;
    check("sim_w_ready", 64'(slv_w_ready), 64'(1));
    check("sim_r_valid_first", 64'(slv_r_valid), 64'(1));
    check("sim_r_last_first", 64'(slv_r_last), 64'(0));
    slv_w_valid = 1'b1; slv_w_last = 1'b1;
    step();
    slv_w_valid = 1'b0; slv_w_last = 1'b0;
    check("sim_b_valid", 64'(slv_b_valid), 64'(1));
    check("sim_b_id", 64'(slv_b_id), 64'(6'h0A));
    check("sim_r_last", 64'(slv_r_last), 64'(1));
    check("sim_r_id", 64'(slv_r_id), 64'(6'h0B));
    check_cnt("sim_cnt_before");
    step();
    slv_r_ready = 1'b0; slv_b_ready = 1'b0;
    model_done(2);
    check("sim_cnt_step", 64'(exp_cnt - c0), 64'(2));
    check_cnt("sim_cnt_plus2");
    check("sim_aw_ready", 64'(slv_aw_ready), 64'(1));
    check("sim_ar_ready", 64'(slv_ar_ready), 64'(1));

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      int mode;
      mode   = $urandom_range(0, 2);
      rid    = IW'($urandom);
      wid    = IW'($urandom);
      rlen   = $urandom_range(0, 20);
      wbeats = $urandom_range(1, 8);
      if (mode == 0) begin
        do_write(wid, wbeats, $urandom_range(0, 3), wid, 2'b11);
      end else if (mode == 1) begin
        do_read(rid, rlen, 1'($urandom_range(0, 1)), rid, rlen + 1, 2'b11);
      end else begin
        fork
          do_write(wid, wbeats, $urandom_range(0, 3), wid, 2'b11);
          do_read(rid, rlen, 1'($urandom_range(0, 1)), rid, rlen + 1, 2'b11);
        join
      end
      check_cnt("cnt_random");
    end

    // Reset while B is pending and the read is on beat 2 of 8
    slv_aw_id = 6'h11; slv_aw_valid = 1'b1;
    slv_ar_id = 6'h22; slv_ar_len = 8'd7; slv_ar_valid = 1'b1;
    step();
    slv_aw_valid = 1'b0; slv_ar_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w_last = 1'b1; slv_r_ready = 1'b1;
    step();
    slv_w_valid = 1'b0; slv_w_last = 1'b0;
    check("pre_rst_b_valid", 64'(slv_b_valid), 64'(1));
    check("pre_rst_r_valid", 64'(slv_r_valid), 64'(1));
    check("pre_rst_r_last", 64'(slv_r_last), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_b_valid", 64'(slv_b_valid), 64'(0));
    check("rst_async_r_valid", 64'(slv_r_valid), 64'(0));
    slv_r_ready = 1'b0;
    exp_cnt = 0;
    check_cnt("rst_cnt_cleared");
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    check("post_rst_aw_ready", 64'(slv_aw_ready), 64'(1));
    check("post_rst_ar_ready", 64'(slv_ar_ready), 64'(1));
    check("post_rst_r_valid", 64'(slv_r_valid), 64'(0));
    check("post_rst_b_valid", 64'(slv_b_valid), 64'(0));
    check_cnt("post_rst_cnt");

    // Reset while the write sits in its data phase
    slv_aw_id = 6'h2B; slv_aw_valid = 1'b1;
    step();
    slv_aw_valid = 1'b0;
    check("wd_w_ready", 64'(slv_w_ready), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_w_ready", 64'(slv_w_ready), 64'(0));
    step();
    #3 rst_n = 1'b1;
    step();
    check("post_rst2_aw_ready", 64'(slv_aw_ready), 64'(1));
    check("post_rst2_w_ready", 64'(slv_w_ready), 64'(0));

    // Traffic after reset still works
    do_read(6'h2A, 3, 1, 6'h2A, 4, 2'b11);
    do_write(6'h15, 4, 1, 6'h15, 2'b11);
    check_cnt("cnt_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cluster_axi_err_slv.md
CLUSTER_AXI_ERR_SLV -- requirements
Module: cluster_axi_err_slv

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width of the slave port.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data width; W strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 6, ID width, matching the crossbar master-side ID width.
REQ-004 SHALL have parameter AXI_USER_WIDTH, default 6, user width; R/B user driven to 0.
REQ-005 SHALL have parameter RESP_DATA, default 64'hBADC_AB1E_BADC_AB1E, value returned on every R beat, truncated to AXI_DATA_WIDTH.
REQ-006 SHALL have port clk_i, input, 1, the single clock.
REQ-007 SHALL have port rst_ni, input, 1; one clock, reset asynchronous and active-low.
REQ-008 SHALL have port slv, AXI_BUS.Slave, parameterised as above, the AXI4 responder end of a crossbar master port.
REQ-009 SHALL, only when the macro of REQ-027 is defined, have port err_cnt_o, output, 16, count of terminated transactions.

Function
REQ-010 SHALL answer every transaction with DECERR (2'b11) and never forward it.
REQ-011 SHALL run independent write and read FSMs; both may be active in the same cycle.
REQ-012 SHALL use write FSM states W_IDLE, W_DATA, W_RESP.
REQ-013 SHALL in W_IDLE drive awready=1 and wready=0; on AW handshake latch awid and go to W_DATA.
REQ-014 SHALL in W_DATA drive wready=1 and awready=0; discard wdata/wstrb; on a W handshake with wlast=1 go to W_RESP.
REQ-015 SHALL in W_RESP drive bvalid=1, bid=latched awid, bresp=DECERR; hold these stable until bready; on the B handshake go to W_IDLE.
REQ-016 SHALL NOT accept W beats before the AW handshake; wready stays 0 in W_IDLE.
REQ-017 SHALL use the W beat count only through wlast; awlen is not checked.
REQ-018 SHALL use read FSM states R_IDLE, R_DATA.
REQ-019 SHALL in R_IDLE drive arready=1; on AR handshake latch arid, load an 8-bit beat counter with arlen, and go to R_DATA.
REQ-020 SHALL in R_DATA drive rvalid=1, rid=latched arid, rdata=RESP_DATA, rresp=DECERR, rlast=(counter==0).
REQ-021 SHALL on each R handshake with counter!=0 decrement the counter and hold R_DATA; with counter==0 go to R_IDLE.
REQ-022 SHALL emit exactly arlen+1 beats; arlen=255 gives 256 beats with no wrap.
REQ-023 SHALL have latency: wready is 1 in the cycle after the AW handshake, bvalid in the cycle after the wlast handshake, the first rvalid in the cycle after the AR handshake, and awready/arready in the cycle after the B/last-R handshake.
REQ-024 SHALL accept at most one outstanding transaction per direction; arready=0 in R_DATA and awready=0 in W_DATA/W_RESP.

Reset
REQ-025 SHALL on rst_ni=0 enter W_IDLE and R_IDLE; the counter, latched IDs and err_cnt_o reset to 0.
REQ-026 SHALL on reset mid-transaction drop bvalid, rvalid and wready to 0 asynchronously, discard the transaction, and assert awready=arready=1 in the first cycle after release.

Configuration
REQ-027 SHALL, with macro CLUSTER_AXI_ERR_SLV_CNT_EN defined, implement err_cnt_o as a 16-bit counter that saturates at 16'hFFFF.
REQ-028 SHALL, with CLUSTER_AXI_ERR_SLV_CNT_EN defined, increment err_cnt_o by 1 per B handshake and by 1 per R handshake with rlast=1, so simultaneous events add 2 and the count saturates at 16'hFFFF.
REQ-029 SHALL, with CLUSTER_AXI_ERR_SLV_CNT_EN undefined, omit the err_cnt_o port and the counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL check: AW id=6'h15, then 4 W beats with wlast on beat 4 -> one B with bid=6'h15, bresp=2'b11, exactly 1 cycle after the wlast handshake.
REQ-031 SHALL check: AR id=6'h2A, arlen=3 -> 4 R beats with rdata=RESP_DATA, rresp=2'b11, and rlast only on beat 4.
REQ-032 SHALL check: AR arlen=255 with rready randomly toggled -> 256 beats, stable R payload while stalled, and arready=0 until the last beat.
REQ-033 SHALL check: AW and AR in the same cycle with bready=rready=1 and arlen=0 -> B and R complete in parallel, and err_cnt_o goes +2 (macro on).
REQ-034 SHALL check: rst_ni pulsed low during R_DATA beat 2 of 8 -> rvalid=0 immediately, arready=1 after release, and err_cnt_o=0.
